mm_systolic_seq: RTL and testbench

- Sequencer for the 3x3 systolic matrix multiplier array of mac_unit cells.
- Accepts a job on start and snapshots both operand matrices.
- Clears the array accumulators, then drives skewed A rows into the array's left edge and B columns into its top edge.
- Waits for the array to drain, latches the 3x3 result and pulses done.

---
 rtl/mm_systolic_seq.sv | 197 +++++++++++++++++++
 tb/tb_mm_systolic_seq.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_systolic_seq.sv
// -----------------------------------------------------------------------------
// mm_systolic_seq
//
// Sequencer for a 3x3 systolic matrix-multiply array built from MAC cells.
// A job is accepted on `start` while idle. Both operand matrices are
// snapshotted at that moment, so later changes on the inputs do not affect
// the job. The job then runs in four phases:
//   CLEAR : one cycle of mac_clr so every accumulator starts from zero.
//   FEED  : five beats (t = 0..4) of skewed data. Row i of A enters lane i
//           delayed by i beats, and column j of B enters lane j delayed by
//           j beats. Matching A[i][k] and B[k][j] therefore meet in cell (i,j).
//   DRAIN : DRAIN_CYCLES idle beats so the last partial products settle.
//   Exit  : the array outputs are latched into result_flat, done pulses for
//           one cycle and job_cnt increments.
// abort cancels a running job without producing a result.
//
// Ports
//   clk, reset    : clock; asynchronous active-high reset
//   start, abort  : job request (sampled in IDLE) / synchronous cancel
//   a_flat,b_flat : operand matrices, element [r][c] at WIDTH*(3r+c)
//   m_flat        : accumulator outputs of the array, same packing
//   a_feed,a_vld  : left-edge lanes (one per array row) and their valids
//   b_feed,b_vld  : top-edge lanes (one per array column) and their valids
//   mac_clr       : accumulator clear to all cells
//   busy          : any state other than IDLE
//   done          : one-cycle completion pulse
//   result_flat   : captured C matrix
//   job_cnt       : completed-job counter (wraps)
// -----------------------------------------------------------------------------
module mm_systolic_seq #(
  parameter int WIDTH        = 8,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [9*WIDTH-1:0]   a_flat,
  input  logic [9*WIDTH-1:0]   b_flat,
  input  logic [9*WIDTH-1:0]   m_flat,
  output logic [3*WIDTH-1:0]   a_feed,
  output logic [3*WIDTH-1:0]   b_feed,
  output logic [2:0]           a_vld,
  output logic [2:0]           b_vld,
  output logic                 mac_clr,
  output logic                 busy,
  output logic                 done,
  output logic [9*WIDTH-1:0]   result_flat,
  output logic [15:0]          job_cnt
);

  localparam int FEED_LAST = 4;
  // One counter serves both FEED beats and DRAIN beats, so it must cover
  // the larger of the two ranges.
  localparam int CNT_MAX = (DRAIN_CYCLES > FEED_LAST + 1) ? DRAIN_CYCLES : FEED_LAST + 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] FEED_END  = CNT_W'(FEED_LAST);
  localparam logic [CNT_W-1:0] DRAIN_END = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [9*WIDTH-1:0]   a_op_q, a_op_d;
  logic [9*WIDTH-1:0]   b_op_q, b_op_d;
  logic [9*WIDTH-1:0]   result_q, result_d;
  logic                 done_q, done_d;
  logic [15:0]          job_cnt_q, job_cnt_d;

  function automatic logic [WIDTH-1:0] elem(input logic [9*WIDTH-1:0] m,
                                            input int r,
                                            input int c);
    return m[WIDTH*(3*r+c) +: WIDTH];
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_op_d    = a_op_q;
    b_op_d    = b_op_q;
    result_d  = result_q;
    done_d    = 1'b0;
    job_cnt_d = job_cnt_q;

    case (state_q)
      S_IDLE: begin
        // abort is ignored here, so start wins when both are high.
        if (start) begin
          a_op_d  = a_flat;
          b_op_d  = b_flat;
          cnt_d   = '0;
          state_d = S_CLEAR;
        end
      end

      S_CLEAR: begin
        cnt_d = '0;
        if (abort) state_d = S_IDLE;
        else       state_d = S_FEED;
      end

      S_FEED: begin
        if (abort) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == FEED_END) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DRAIN: begin
        // abort outranks the capture on the final drain beat.
        if (abort) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == DRAIN_END) begin
          result_d  = m_flat;
          done_d    = 1'b1;
          job_cnt_d = job_cnt_q + 16'd1;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_op_q    <= '0;
      b_op_q    <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      job_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_op_q    <= a_op_d;
      b_op_q    <= b_op_d;
      result_q  <= result_d;
      done_q    <= done_d;
      job_cnt_q <= job_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Feed decode: purely from registered state, count and operands, so the
  // array never sees a combinational path from start or the data inputs.
  // Lane l carries element index k = t - l while 0 <= k <= 2.
  // ---------------------------------------------------------------------------
  for (genvar l = 0; l < 3; l++) begin : g_lane
    int   k;
    int   k_sel;
    logic in_win;

    assign k      = int'(cnt_q) - l;
    assign in_win = (state_q == S_FEED) && (k >= 0) && (k <= 2);
    // Park the select on a legal element outside the window; the value is
    // masked anyway.
    assign k_sel  = in_win ? k : 0;

    assign a_feed[WIDTH*l +: WIDTH] = in_win ? elem(a_op_q, l, k_sel) : '0;
    assign b_feed[WIDTH*l +: WIDTH] = in_win ? elem(b_op_q, k_sel, l) : '0;
    assign a_vld[l]                 = in_win;
    assign b_vld[l]                 = in_win;
  end

  assign mac_clr     = (state_q == S_CLEAR);
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign result_flat = result_q;
  assign job_cnt     = job_cnt_q;

endmodule

// File: tb/tb_mm_systolic_seq.sv
// -----------------------------------------------------------------------------
// tb_mm_systolic_seq
//
// Drives the sequencer into a behavioural 3x3 systolic array of MAC cells
// (a operands move right, b operands move down, one hop per cycle). Results
// are compared with a plain matrix product taken modulo 2^W. Feed lanes are
// compared beat by beat with the skew rule A[i][t-i] / B[t-j][j].
// -----------------------------------------------------------------------------
module tb_mm_systolic_seq;

  localparam int W = 8;
  localparam int D = 3;

  logic              clk = 1'b0;
  logic              reset, start, abort;
  logic [9*W-1:0]    a_flat, b_flat, m_flat;
  logic [3*W-1:0]    a_feed, b_feed;
  logic [2:0]        a_vld, b_vld;
  logic              mac_clr, busy, done;
  logic [9*W-1:0]    result_flat;
  logic [15:0]       job_cnt;

  int                checks   = 0;
  int                failures = 0;
  logic [15:0]       exp_jobs = '0;
  logic [9*W-1:0]    exp_result = '0;

  always #5 clk = ~clk;

  mm_systolic_seq #(.WIDTH(W), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .a_flat(a_flat), .b_flat(b_flat), .m_flat(m_flat),
    .a_feed(a_feed), .b_feed(b_feed), .a_vld(a_vld), .b_vld(b_vld),
    .mac_clr(mac_clr), .busy(busy), .done(done),
    .result_flat(result_flat), .job_cnt(job_cnt)
  );

  // ---------------- behavioural systolic array ----------------
  logic [W-1:0] acc [3][3];
  logic [W-1:0] ap  [3][3];
  logic [W-1:0] bp  [3][3];
  logic         av  [3][3];
  logic         bv  [3][3];
  logic [W-1:0] ain [3][3];
  logic [W-1:0] bin [3][3];
  logic         avin[3][3];
  logic         bvin[3][3];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        ain[i][j]  = '0;
        bin[i][j]  = '0;
        avin[i][j] = 1'b0;
        bvin[i][j] = 1'b0;
        if (j == 0) begin
          ain[i][j]  = a_feed[W*i +: W];
          avin[i][j] = a_vld[i];
        end else begin
          ain[i][j]  = ap[i][j-1];
          avin[i][j] = av[i][j-1];
        end
        if (i == 0) begin
          bin[i][j]  = b_feed[W*j +: W];
          bvin[i][j] = b_vld[j];
        end else begin
          bin[i][j]  = bp[i-1][j];
          bvin[i][j] = bv[i-1][j];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (reset) begin
          acc[i][j] <= '0; ap[i][j] <= '0; bp[i][j] <= '0;
          av[i][j]  <= 1'b0; bv[i][j] <= 1'b0;
        end else begin
          ap[i][j] <= ain[i][j];
          bp[i][j] <= bin[i][j];
          av[i][j] <= avin[i][j];
          bv[i][j] <= bvin[i][j];
          if (mac_clr)
            acc[i][j] <= '0;
          else if (avin[i][j] && bvin[i][j])
            acc[i][j] <= acc[i][j] + ain[i][j] * bin[i][j];
        end
      end
    end
  end

  always_comb begin
    m_flat = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        m_flat[W*(3*i+j) +: W] = acc[i][j];
  end

  // ---------------- reference model ----------------
  function automatic logic [9*W-1:0] matmul(input logic [9*W-1:0] a,
                                            input logic [9*W-1:0] b);
    logic [9*W-1:0] res;
    int s;
    res = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        s = 0;
        for (int k = 0; k < 3; k++)
          s += int'(a[W*(3*r+k) +: W]) * int'(b[W*(3*k+c) +: W]);
        res[W*(3*r+c) +: W] = W'(s);
      end
    end
    return res;
  endfunction

  function automatic logic [3*W-1:0] exp_feed(input logic [9*W-1:0] m,
                                              input int t, input bit is_b);
    logic [3*W-1:0] v;
    v = '0;
    for (int l = 0; l < 3; l++) begin
      if (t - l >= 0 && t - l <= 2) begin
        if (is_b) v[W*l +: W] = m[W*(3*(t-l)+l) +: W];
        else      v[W*l +: W] = m[W*(3*l+(t-l)) +: W];
      end
    end
    return v;
  endfunction

  function automatic logic [2:0] exp_vld(input int t);
    logic [2:0] v;
    v = '0;
    for (int l = 0; l < 3; l++)
      if (t - l >= 0 && t - l <= 2) v[l] = 1'b1;
    return v;
  endfunction

  function automatic logic [9*W-1:0] rmat();
    logic [9*W-1:0] m;
    for (int i = 0; i < 9; i++) m[W*i +: W] = W'($urandom);
    return m;
  endfunction

  function automatic logic [9*W-1:0] fill(input int v);
    logic [9*W-1:0] m;
    for (int i = 0; i < 9; i++) m[W*i +: W] = W'(v);
    return m;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Caller has just set a_flat/b_flat and start=1 after a falling edge.
  // Phase ph: 0 = CLEAR, 1..5 = FEED t=ph-1, 6..5+D = DRAIN.
  task automatic do_job(input int abort_at, input int rst_at, input bit poke);
    logic [9*W-1:0] sa, sb, exp_c;
    sa    = a_flat;
    sb    = b_flat;
    exp_c = matmul(sa, sb);
    for (int ph = 0; ph <= 5 + D; ph++) begin
      @(negedge clk);
      if (ph == 0) begin
        start  = 1'b0;
        abort  = 1'b0;
        a_flat = rmat();
        b_flat = rmat();
      end
      chk("busy", busy, 1'b1);
      chk("mac_clr", mac_clr, (ph == 0));
      chk("done_low", done, 1'b0);
      if (ph >= 1 && ph <= 5) begin
        chk($sformatf("a_feed_t%0d", ph-1), a_feed, exp_feed(sa, ph-1, 1'b0));
        chk($sformatf("b_feed_t%0d", ph-1), b_feed, exp_feed(sb, ph-1, 1'b1));
        chk($sformatf("a_vld_t%0d", ph-1), a_vld, exp_vld(ph-1));
        chk($sformatf("b_vld_t%0d", ph-1), b_vld, exp_vld(ph-1));
      end else begin
        chk("vld_idle", {a_vld, b_vld}, 6'b0);
        chk("feed_idle", {a_feed, b_feed}, '0);
      end
      if (poke) begin
        if (ph == 2 || ph == 6) start = 1'b1;
        if (ph == 3 || ph == 7) start = 1'b0;
      end
      if (ph == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_vld", {a_vld, b_vld, mac_clr, done}, 8'b0);
        chk("abort_feed", {a_feed, b_feed}, '0);
        chk("abort_result", result_flat, exp_result);
        chk("abort_jobcnt", job_cnt, exp_jobs);
        return;
      end
      if (ph == rst_at) begin
        #2 reset = 1'b1;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_ctl", {mac_clr, done, a_vld, b_vld}, 8'b0);
        chk("rst_result", result_flat, '0);
        chk("rst_jobcnt", job_cnt, 16'd0);
        exp_jobs   = '0;
        exp_result = '0;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
    end
    @(negedge clk);
    exp_jobs   = exp_jobs + 16'd1;
    exp_result = exp_c;
    chk("done_pulse", done, 1'b1);
    chk("done_busy", busy, 1'b0);
    chk("result", result_flat, exp_c);
    chk("job_cnt", job_cnt, exp_jobs);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9*W-1:0] ma, mb;

    reset  = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    a_flat = '0;
    b_flat = '0;
    #12;
    chk("reset_busy", busy, 1'b0);
    chk("reset_ctl", {done, mac_clr, a_vld, b_vld}, 8'b0);
    chk("reset_feed", {a_feed, b_feed}, '0);
    chk("reset_result", result_flat, '0);
    chk("reset_jobcnt", job_cnt, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Skew pattern: A[r][c]=16r+c, B[r][c]=0x80+16r+c
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        ma[W*(3*r+c) +: W] = W'(16*r + c);
        mb[W*(3*r+c) +: W] = W'(8'h80 + 16*r + c);
      end
    a_flat = ma; b_flat = mb; start = 1'b1;
    do_job(-1, -1, 1'b0);

    // Identity times B returns B
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        ma[W*(3*r+c) +: W] = (r == c) ? W'(1) : W'(0);
        mb[W*(3*r+c) +: W] = W'(3*r + c + 1);
      end
    a_flat = ma; b_flat = mb; start = 1'b1;
    do_job(-1, -1, 1'b0);
    chk("identity", result_flat, mb);

    // Ones x twos, then wrap-around case
    a_flat = fill(1); b_flat = fill(2); start = 1'b1;
    do_job(-1, -1, 1'b0);
    chk("ones_twos", result_flat, fill(6));
    a_flat = fill(16); b_flat = fill(16); start = 1'b1;
    do_job(-1, -1, 1'b0);
    chk("sixteens", result_flat, fill(0));

    // start pulsed mid-job is ignored; start in the done cycle is accepted
    a_flat = rmat(); b_flat = rmat(); start = 1'b1;
    do_job(-1, -1, 1'b1);
    a_flat = rmat(); b_flat = rmat(); start = 1'b1;
    do_job(-1, -1, 1'b0);
    @(negedge clk);
    chk("no_requeue_busy", busy, 1'b0);
    chk("no_requeue_done", done, 1'b0);

    // abort at FEED t=2, then a clean job
    a_flat = rmat(); b_flat = rmat(); start = 1'b1;
    do_job(3, -1, 1'b0);
    repeat (D + 6) @(negedge clk);
    chk("abort_quiet_done", done, 1'b0);
    chk("abort_quiet_cnt", job_cnt, exp_jobs);
    a_flat = rmat(); b_flat = rmat(); start = 1'b1;
    do_job(-1, -1, 1'b0);

    // abort on the final drain beat beats the capture
    a_flat = rmat(); b_flat = rmat(); start = 1'b1;
    do_job(5 + D, -1, 1'b0);
    @(negedge clk);
    chk("late_abort_done", done, 1'b0);

    // start and abort together in IDLE: start wins
    a_flat = rmat(); b_flat = rmat(); start = 1'b1; abort = 1'b1;
    do_job(-1, -1, 1'b0);

    // random jobs
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      a_flat = rmat(); b_flat = rmat(); start = 1'b1;
      do_job(-1, -1, 1'b0);
    end

    // asynchronous reset during DRAIN, then a fresh job
    a_flat = rmat(); b_flat = rmat(); start = 1'b1;
    do_job(7, -1 + 8, 1'b0);
    a_flat = rmat(); b_flat = rmat(); start = 1'b1;
    do_job(-1, 7, 1'b0);
    a_flat = rmat(); b_flat = rmat(); start = 1'b1;
    do_job(-1, -1, 1'b0);

    // counter wrap from 0xFFFF
    @(negedge clk);
    force dut.job_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.job_cnt_q;
    @(negedge clk);
    exp_jobs = 16'hFFFF;
    chk("preload_cnt", job_cnt, 16'hFFFF);
    a_flat = rmat(); b_flat = rmat(); start = 1'b1;
    do_job(-1, -1, 1'b0);
    chk("wrap_cnt", job_cnt, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
